// File: rtl/multi_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debounce_pkg
//  Description : Shared constants for the multi-channel debouncer: one-hot
//                state encoding and state register width.
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_debounce_pkg;

  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  // One-hot per-channel debounce states
  localparam state_t IDLE         = 4'b0001;
  localparam state_t WAIT_PRESS   = 4'b0010;
  localparam state_t PRESSED      = 4'b0100;
  localparam state_t WAIT_RELEASE = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One push-button channel: 2-flop synchroniser, debounce
//                counter, 4-state one-hot FSM and registered press/release
//                pulses. Optional long-press detection is compiled in when
//                MULTI_DEBOUNCE_HOLD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic debounced,
  output logic press_pulse,
`ifdef MULTI_DEBOUNCE_HOLD_EN
  output logic held,
`endif
  output logic release_pulse
);

  // Terminal count: the input must be seen stable on this many edges after
  // entering a WAIT state before the level change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             sync_in;
  logic             cnt_done;

  assign sync_in  = sync2_q;
  assign cnt_done = (cnt_q == CNT_LAST);

  // State register plus synchroniser, counter and pulse flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  // Next-state and counter logic; counter cleared on each WAIT entry and
  // compared before incrementing so it can never wrap
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync_in) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_in) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_in) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync_in) begin
          state_d = PRESSED;
        end else if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: level from registered state, pulses armed on the
  // accepting transitions so they line up with the level change
  always_comb begin
    debounced       = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
    press_pulse_d   = (state_q == WAIT_PRESS)   &&  sync_in && cnt_done;
    release_pulse_d = (state_q == WAIT_RELEASE) && !sync_in && cnt_done;
  end

  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef MULTI_DEBOUNCE_HOLD_EN
  localparam int              HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Long-press counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Count while pressed, saturate at the threshold, clear when released
  always_comb begin
    hold_cnt_d = '0;
    if (debounced) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end
  end

  // Gating with debounced makes held drop together with the release pulse
  assign held = debounced && (hold_cnt_q == HOLD_MAX);
`endif

endmodule
`default_nettype wire

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debounce
//  Description : NUM_CH independent push-button debouncers with clean level
//                and single-cycle press/release pulses per channel.
//                Define MULTI_DEBOUNCE_HOLD_EN to add the per-channel
//                long-press output 'held'.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] debounced,
  output logic [NUM_CH-1:0] press_pulse,
`ifdef MULTI_DEBOUNCE_HOLD_EN
  output logic [NUM_CH-1:0] held,
`endif
  output logic [NUM_CH-1:0] release_pulse
);

  // One fully independent debouncer per button
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .button        (button[i]),
      .debounced     (debounced[i]),
      .press_pulse   (press_pulse[i]),
`ifdef MULTI_DEBOUNCE_HOLD_EN
      .held          (held[i]),
`endif
      .release_pulse (release_pulse[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_debounce
//  Description : Scoreboard bench for multi_debounce. A reference model fed
//                from the raw buttons predicts every cycle's outputs; the
//                prediction is queued at each rising edge and compared on the
//                following falling edge. Covers MULTI_DEBOUNCE_HOLD_EN too.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] button  = '0;
  logic [NUM_CH-1:0] debounced;
  logic [NUM_CH-1:0] press_pulse;
  logic [NUM_CH-1:0] release_pulse;
  logic [NUM_CH-1:0] held_obs;

  int n_vec = 0;
  int n_err = 0;

  multi_debounce #(
    .NUM_CH          (NUM_CH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .button        (button),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
`ifdef MULTI_DEBOUNCE_HOLD_EN
    .held          (held_obs),
`endif
    .release_pulse (release_pulse)
  );

`ifndef MULTI_DEBOUNCE_HOLD_EN
  assign held_obs = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({debounced, press_pulse, release_pulse, held_obs});
  endfunction

  // ---------------- reference model ----------------
  // A level flips once the synchronised input has disagreed with it on
  // DEB+1 consecutive edges (first edge enters the WAIT state).
  logic [NUM_CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [NUM_CH-1:0] m_press = '0, m_rel = '0, m_held = '0;
  int                m_run  [NUM_CH];
  int                m_hold [NUM_CH];
  logic [31:0]       sb_q[$];

  always @(posedge clk or negedge reset_n) begin : model
    logic [NUM_CH-1:0] sync_now;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_held = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
      sb_q.delete();
    end else begin
      sync_now = m_s2;
      m_s2     = m_s1;
      m_s1     = button;
      m_press  = '0;
      m_rel    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_lvl[c]) begin
          if (m_hold[c] < HOLD) m_hold[c]++;
        end else begin
          m_hold[c] = 0;
        end
        if (sync_now[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) m_press[c] = 1'b1;
            else          m_rel[c]   = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef MULTI_DEBOUNCE_HOLD_EN
        m_held[c] = m_lvl[c] && (m_hold[c] == HOLD);
`else
        m_held[c] = 1'b0;
`endif
      end
      sb_q.push_back(32'({m_lvl, m_press, m_rel, m_held}));
    end
  end

  // ---------------- monitor ----------------
  int db1_cnt = 0;
  int rel2_cnt = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sb_q.size() > 0) chk("cycle", outs(), sb_q.pop_front());
      if (debounced[1] || press_pulse[1]) db1_cnt++;
      if (release_pulse[2]) rel2_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop reset between edges, check outputs clear immediately, then release
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk(tag, outs(), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int snap;
    reset_n = 1'b0;
    button  = '0;
    tick(3);
    #1 chk("reset_state", outs(), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Clean press on channel 0
    button = 4'b0001;
    tick(8);
    #1 chk("press_ch0_level", 32'(debounced), 32'h1);
    button = 4'b0000;
    tick(10);

    // Bounce on channel 1 never reaches the threshold
    #1 snap = db1_cnt;
    for (int k = 0; k < 4; k++) begin
      button[1] = (k % 2 == 0);
      tick(2);
    end
    button[1] = 1'b0;
    tick(10);
    #1 chk("bounce_ch1_activity", 32'(db1_cnt - snap), 32'd0);

    // Release with bounce on channel 2
    button[2] = 1'b1;
    tick(10);
    #1 snap = rel2_cnt;
    button[2] = 1'b0;
    tick(2);
    button[2] = 1'b1;
    tick(1);
    button[2] = 1'b0;
    tick(10);
    #1 chk("release_ch2_pulses", 32'(rel2_cnt - snap), 32'd1);

    // All channels together, held long enough to reach the hold threshold
    button = 4'b1111;
    tick(8);
    #1 chk("simul_level", 32'(debounced), 32'hf);
    tick(20);
    button = 4'b0000;
    tick(12);

    // Long press on channel 3
    button = 4'b1000;
    tick(25);
`ifdef MULTI_DEBOUNCE_HOLD_EN
    #1 chk("held_ch3", 32'(held_obs), 32'h8);
`endif
    button = 4'b0000;
    tick(12);

    // Reset while channel 0 is waiting; a fresh press needs full latency
    button = 4'b0001;
    tick(3);
    async_reset("rst_wait_press");
    tick(6);
    #1 chk("rst_relatch_early", 32'(debounced), 32'h0);
    tick(2);
    #1 chk("rst_relatch_done", 32'(debounced), 32'h1);

    // Reset while channel 0 is pressed
    async_reset("rst_pressed");
    tick(10);
    button = 4'b0000;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
